// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - UART transmitter with a small TX FIFO, oversampled bit timing
// Frames are popped from the FIFO and serialized start/data/parity/stop; tx is registered.
module uart_tx_fifo #(
  parameter int DATA_W     = 8,
  parameter int DEPTH      = 4,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1
) (
  input  logic                     mclkx16,
  input  logic                     reset,
  input  logic                     write,
  input  logic [DATA_W-1:0]        data,
  input  logic [1:0]               parity_mode,
  output logic                     tx,
  output logic                     txrdy,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [LW-1:0] FULL_LVL  = LW'(DEPTH);
  localparam logic [CW-1:0] CNT_LAST  = CW'(OVERSAMPLE - 1);
  localparam logic [3:0]    LAST_DATA = 4'(DATA_W - 1);
  localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t             state;
  logic [DATA_W-1:0]  mem [DEPTH];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [CW-1:0]      cnt;
  logic [3:0]         bit_idx;
  logic [DATA_W-1:0]  frame;
  logic               par_en;
  logic               par_bit;
  logic [DATA_W-1:0]  head;
  logic               empty;
  logic               full;
  logic               bit_end;
  logic               pop;
  logic               push;

  always_comb begin
    head    = mem[rd_ptr];
    empty   = (fifo_level == '0);
    full    = (fifo_level == FULL_LVL);
    bit_end = (cnt == CNT_LAST);
    // A pop happens either from IDLE or exactly at the end of the last stop period
    pop     = !empty && ((state == IDLE) ||
              ((state == STOP) && bit_end && (bit_idx == LAST_STOP)));
    push    = write && (!full || pop);
  end

  assign txrdy = !full;

  always_ff @(posedge mclkx16) begin
    if (push)
      mem[wr_ptr] <= data;
  end

  always_ff @(posedge mclkx16 or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
      overflow <= write && full && !pop;
    end
  end

  always_ff @(posedge mclkx16 or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      tx      <= 1'b1;
      busy    <= 1'b0;
      cnt     <= '0;
      bit_idx <= '0;
      frame   <= '0;
      par_en  <= 1'b0;
      par_bit <= 1'b0;
    end else if (pop) begin
      state   <= START;
      busy    <= 1'b1;
      tx      <= 1'b0;
      cnt     <= '0;
      bit_idx <= '0;
      frame   <= head;
      par_en  <= ^parity_mode;
      par_bit <= (^head) ^ parity_mode[1];
    end else begin
      if (state != IDLE)
        cnt <= bit_end ? '0 : cnt + CW'(1);
      case (state)
        IDLE: begin
          tx   <= 1'b1;
          busy <= 1'b0;
        end
        START: begin
          if (bit_end) begin
            state <= DATA;
            tx    <= frame[0];
          end
        end
        DATA: begin
          if (bit_end) begin
            frame <= frame >> 1;
            if (bit_idx == LAST_DATA) begin
              bit_idx <= '0;
              if (par_en) begin
                state <= PARITY;
                tx    <= par_bit;
              end else begin
                state <= STOP;
                tx    <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + 4'd1;
              tx      <= frame[1];
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            state <= STOP;
            tx    <= 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (bit_idx == LAST_STOP) begin
              state <= IDLE;
              tx    <= 1'b1;
              busy  <= 1'b0;
            end else begin
              bit_idx <= bit_idx + 4'd1;
            end
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo
// Line activity is logged each cycle and compared against frames built from the UART rules.
module tb_uart_tx_fifo;

  localparam int OS = 16;

  logic       mclkx16 = 1'b0;
  logic       reset = 1'b1;
  logic       write = 1'b0;
  logic       write2 = 1'b0;
  logic [7:0] data = 8'h00;
  logic [7:0] data2 = 8'h00;
  logic [1:0] parity_mode = 2'b00;
  logic [1:0] parity_mode2 = 2'b00;
  logic       tx, txrdy, busy, overflow;
  logic       tx2, txrdy2, busy2, overflow2;
  logic [2:0] fifo_level, fifo_level2;

  always #5 mclkx16 = ~mclkx16;

  uart_tx_fifo dut (
    .mclkx16(mclkx16), .reset(reset), .write(write), .data(data),
    .parity_mode(parity_mode), .tx(tx), .txrdy(txrdy), .busy(busy),
    .fifo_level(fifo_level), .overflow(overflow)
  );

  uart_tx_fifo #(.STOP_BITS(2)) dut2 (
    .mclkx16(mclkx16), .reset(reset), .write(write2), .data(data2),
    .parity_mode(parity_mode2), .tx(tx2), .txrdy(txrdy2), .busy(busy2),
    .fifo_level(fifo_level2), .overflow(overflow2)
  );

  int   checks = 0;
  int   failures = 0;
  logic rec_on = 1'b0;
  logic rec_sel = 1'b0;
  logic log_tx [0:4095];
  logic log_busy [0:4095];
  int   log_n = 0;
  bit   exp_bits [$];

  always @(negedge mclkx16) begin
    if (!rec_on)
      log_n = 0;
    else if (log_n < 4096) begin
      log_tx[log_n]   = rec_sel ? tx2 : tx;
      log_busy[log_n] = rec_sel ? busy2 : busy;
      log_n = log_n + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic add_frame(input logic [7:0] d, input logic [1:0] mode, input int stops);
    int ones;
    ones = $countones(d);
    exp_bits.push_back(1'b0);
    for (int i = 0; i < 8; i++)
      exp_bits.push_back(d[i]);
    if (mode == 2'b01)
      exp_bits.push_back(ones % 2 == 1);
    else if (mode == 2'b10)
      exp_bits.push_back(ones % 2 == 0);
    for (int i = 0; i < stops; i++)
      exp_bits.push_back(1'b1);
  endtask

  task automatic start_rec(input logic sel);
    rec_sel = sel;
    rec_on  = 1'b1;
  endtask

  // Log entry 0 is the cycle right after the first write edge; the frame line follows from entry 1.
  task automatic check_rec(input string tag, input int pad);
    int total, nline, bad_tx, bad_busy, first_bad;
    logic et, eb;
    nline = exp_bits.size() * OS;
    total = 1 + nline + pad;
    repeat (total + 1) @(posedge mclkx16);
    #1;
    bad_tx = 0; bad_busy = 0; first_bad = -1;
    for (int i = 0; i < total; i++) begin
      et = (i == 0 || i > nline) ? 1'b1 : exp_bits[(i - 1) / OS];
      eb = (i >= 1 && i <= nline);
      if (i >= log_n || log_tx[i] !== et) begin
        bad_tx++;
        if (first_bad < 0) first_bad = i;
      end
      if (i >= log_n || log_busy[i] !== eb)
        bad_busy++;
    end
    chk($sformatf("%s_tx_mismatches(first_cycle=%0d)", tag, first_bad), bad_tx, 0);
    chk({tag, "_busy_mismatches"}, bad_busy, 0);
    rec_on = 1'b0;
    exp_bits.delete();
    @(posedge mclkx16);
    #1;
  endtask

  task automatic write_one(input logic [7:0] d);
    data  = d;
    write = 1'b1;
    @(posedge mclkx16);
    #1;
    write = 1'b0;
  endtask

  task automatic send_single(input string tag, input logic [7:0] d, input logic [1:0] mode);
    parity_mode = mode;
    write_one(d);
    chk({tag, "_level_after_write"}, fifo_level, 1);
    add_frame(d, mode, 1);
    start_rec(1'b0);
    @(posedge mclkx16);
    #1;
    parity_mode = 2'($urandom_range(0, 3));
    check_rec(tag, 8);
  endtask

  initial begin
    int lows;
    logic [7:0] rd;
    logic [1:0] rm;

    repeat (3) @(posedge mclkx16);
    #1;
    chk("reset_tx", tx, 1);
    chk("reset_txrdy", txrdy, 1);
    chk("reset_busy", busy, 0);
    chk("reset_level", fifo_level, 0);
    chk("reset_overflow", overflow, 0);
    chk("reset_tx2", tx2, 1);

    reset = 1'b0;
    send_single("even_55", 8'h55, 2'b01);
    send_single("odd_55", 8'h55, 2'b10);
    send_single("mode11", 8'($urandom_range(0, 255)), 2'b11);
    for (int k = 0; k < 6; k++) begin
      rd = 8'($urandom_range(0, 255));
      rm = 2'($urandom_range(0, 3));
      send_single($sformatf("rand%0d", k), rd, rm);
    end

    parity_mode2 = 2'b00;
    data2  = 8'hA3;
    write2 = 1'b1;
    @(posedge mclkx16);
    #1;
    write2 = 1'b0;
    add_frame(8'hA3, 2'b00, 2);
    start_rec(1'b1);
    check_rec("stop2_a3", 8);

    parity_mode = 2'b01;
    write_one(8'h10);
    start_rec(1'b0);
    add_frame(8'h10, 2'b01, 1);
    @(posedge mclkx16);
    #1;
    chk("burst_busy", busy, 1);
    chk("burst_level0", fifo_level, 0);
    for (int i = 0; i < 5; i++) begin
      data  = 8'h20 + 8'(i);
      write = 1'b1;
      @(posedge mclkx16);
      #1;
      if (i < 4) begin
        add_frame(8'h20 + 8'(i), 2'b01, 1);
        chk($sformatf("burst_level_w%0d", i), fifo_level, i + 1);
        chk($sformatf("burst_overflow_w%0d", i), overflow, 0);
        chk($sformatf("burst_txrdy_w%0d", i), txrdy, (i < 3) ? 1 : 0);
      end else begin
        chk("overflow_pulse", overflow, 1);
        chk("overflow_level", fifo_level, 4);
        chk("overflow_txrdy", txrdy, 0);
      end
    end
    write = 1'b0;
    @(posedge mclkx16);
    #1;
    chk("overflow_one_cycle", overflow, 0);
    chk("overflow_level_hold", fifo_level, 4);
    check_rec("burst", 8);

    parity_mode = 2'b00;
    data  = 8'h01;
    write = 1'b1;
    @(posedge mclkx16);
    #1;
    start_rec(1'b0);
    data = 8'h02;
    @(posedge mclkx16);
    #1;
    data = 8'h03;
    @(posedge mclkx16);
    #1;
    write = 1'b0;
    add_frame(8'h01, 2'b00, 1);
    add_frame(8'h02, 2'b00, 1);
    add_frame(8'h03, 2'b00, 1);
    check_rec("b2b_123", 8);

    parity_mode = 2'b01;
    data  = 8'h11;
    write = 1'b1;
    @(posedge mclkx16);
    #1;
    @(posedge mclkx16);
    #1;
    @(posedge mclkx16);
    #1;
    write = 1'b0;
    chk("abort_level_queued", fifo_level, 2);
    repeat (58) @(posedge mclkx16);
    #2;
    chk("abort_tx_before", tx, 0);
    reset = 1'b1;
    #1;
    chk("abort_tx_async", tx, 1);
    chk("abort_level", fifo_level, 0);
    chk("abort_busy", busy, 0);
    chk("abort_txrdy", txrdy, 1);
    @(posedge mclkx16);
    #1;
    reset = 1'b0;
    lows = 0;
    repeat (600) begin
      @(posedge mclkx16);
      #1;
      if (tx !== 1'b1 || busy !== 1'b0)
        lows++;
    end
    chk("abort_no_more_frames", lows, 0);
    chk("abort_level_after", fifo_level, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter DATA_W, default 8, meaning data bits per frame (5..9).
REQ-002 Parameter DEPTH, default 4, meaning TX FIFO entries (power of two, 2..64).
REQ-003 Parameter OVERSAMPLE, default 16, meaning mclkx16 cycles per bit period (4..64).
REQ-004 Parameter STOP_BITS, default 1, meaning stop bits per frame (1 or 2).
REQ-005 Port mclkx16  input  1  clock; all state changes on its rising edge.
REQ-006 Port reset  input  1  reset, asynchronous, active-high.
REQ-007 Port write  input  1  synchronous single-cycle write strobe; pushes data into the FIFO.
REQ-008 Port data  input  DATA_W  frame payload, sampled when write=1.
REQ-009 Port parity_mode  input  2  00 none, 01 even, 10 odd, 11 none.
REQ-010 Port tx  output  1  serial line; idle high.
REQ-011 Port txrdy  output  1  high when the FIFO is not full.
REQ-012 Port busy  output  1  high while a frame is on the line (any state other than IDLE).
REQ-013 Port fifo_level  output  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.
REQ-014 Port overflow  output  1  one-cycle pulse when a write is dropped.

Function
REQ-015 The block SHALL be fully synchronous to mclkx16; write is level-sampled, not edge-clocked.
REQ-016 A write with FIFO not full SHALL store data and increment fifo_level on the next cycle.
REQ-017 A write with FIFO full and no pop in the same cycle SHALL be dropped, with overflow=1 for exactly that next cycle.
REQ-018 A write with FIFO full and a pop in the same cycle SHALL be accepted; fifo_level unchanged.
REQ-019 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP.
REQ-020 In IDLE with FIFO non-empty, the FSM SHALL pop the head entry, latch parity_mode, and enter START on the next cycle.
REQ-021 Each bit state SHALL hold tx for exactly OVERSAMPLE cycles, timed by a bit counter cleared on frame load.
REQ-022 START drives tx=0; DATA drives DATA_W bits LSB first; PARITY drives the parity bit; STOP drives tx=1 for STOP_BITS bit periods.
REQ-023 PARITY SHALL be skipped when the latched mode is 00 or 11.
REQ-024 Even parity bit SHALL equal XOR of the data bits; odd parity bit SHALL equal its inverse.
REQ-025 A parity_mode change mid-frame SHALL NOT affect the frame in flight.
REQ-026 At the end of the final stop period: with FIFO non-empty, the FSM SHALL pop and enter START directly, with no idle gap; otherwise it SHALL enter IDLE.
REQ-027 Frame length SHALL be (1+DATA_W+P+STOP_BITS)*OVERSAMPLE cycles, where P=1 when parity is enabled, else 0.
REQ-028 Latency: tx SHALL fall to 0 two cycles after the write cycle into an empty FIFO with the FSM in IDLE.
REQ-029 tx SHALL be driven from a register (glitch-free).
REQ-030 FIFO read/write pointers SHALL wrap modulo DEPTH; fifo_level SHALL never exceed DEPTH or underflow.

Reset
REQ-031 While reset=1: tx=1, txrdy=1, busy=0, fifo_level=0, overflow=0, FSM=IDLE, all counters 0, FIFO emptied.
REQ-032 Reset asserted mid-frame SHALL abort the frame immediately (tx=1 asynchronously); queued data SHALL be discarded.
REQ-033 The first write accepted SHALL be the one sampled on the first mclkx16 edge after reset deasserts.

Verification
REQ-034 Defaults, even parity, write 0x55 -> tx: 0 x16, then 1,0,1,0,1,0,1,0 x16 each, parity 0 x16, stop 1 x16; busy high for 176 cycles.
REQ-035 Odd parity, write 0x55 -> parity bit 1; all other bits identical to REQ-034.
REQ-036 parity_mode=00, STOP_BITS=2, write 0xA3 -> 0, then 1,1,0,0,0,1,0,1, then 1,1; 176 cycles; no parity bit.
REQ-037 FSM busy, DEPTH=4: 5 consecutive writes -> fifo_level 4, txrdy=0, fifth dropped, overflow pulses once.
REQ-038 Queue 0x01,0x02,0x03 -> three frames back-to-back with no idle cycle between stop and start; busy falls after the third.
REQ-039 Reset asserted at cycle 60 of a frame with 2 entries queued -> tx=1 same cycle, fifo_level=0, no further frames sent.
